// File: rtl/dac_play_pkg.sv
// Shared types and sizing helpers for the DAC playback controller.
`timescale 1ns/1ps
package dac_play_pkg;

   // Playback controller states.
   typedef enum logic [2:0] {
      IDLE,
      PREFILL,
      ARM,
      PLAY,
      FLUSH
   } state_t;

   // Width of the underrun gap counter.
   localparam int UCNT_W = 16;

   // Bits needed for a counter that runs 0 .. n-1; never narrower than 1 bit.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear that holds at its all-ones value.
`timescale 1ns/1ps
module sat_counter #(
   parameter int W = 16
) (
   input  logic         rd_clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] cnt
);

   // Clear has priority over increment; increment stops at all ones.
   always_ff @(posedge rd_clk) begin
      // NOTE: sequential state is written with <= so every register samples
      // pre-edge values, regardless of statement order or block order.
      if (rst || clr) begin
         cnt <= '0;
      end else if (inc && (cnt != '1)) begin
         cnt <= cnt + W'(1);
      end
   end

endmodule

// File: rtl/dac_playback_ctrl.sv
// Read-side playback controller: gates the DDR read FIFO, feeds the DAC,
// and tracks underruns, arm timeouts and the number of words played.
`timescale 1ns/1ps
module dac_playback_ctrl
   import dac_play_pkg::*;
#(
   parameter int DATA_W        = 32,
   parameter int SAMPLE_W      = 16,
   parameter int LEN_W         = 32,
   parameter int PREFILL_WORDS = 256,
   parameter int ARM_TIMEOUT   = 1024,
   parameter int FLUSH_QUIET   = 16,
   parameter int SWAP_HALVES   = 0
) (
   input  logic              rd_clk,
   input  logic              rst,
   input  logic              start,
   input  logic              stop,
   input  logic [LEN_W-1:0]  play_len,
   input  logic [LEN_W-1:0]  ddr_wr_word_cnt,
   output logic              ctrl_rd_en,
   input  logic [DATA_W-1:0] fifo_dout,
   input  logic              fifo_dout_valid,
   output logic [DATA_W-1:0] dac_data,
   output logic              dac_valid,
   output logic              underrun,
   output logic [UCNT_W-1:0] underrun_cnt,
   output logic              timeout_err,
   output logic [LEN_W-1:0]  words_played,
   output logic              busy,
   output logic              done
);

   localparam int ARM_CNT_W   = cnt_width(ARM_TIMEOUT);
   localparam int QUIET_CNT_W = cnt_width(FLUSH_QUIET);

   localparam logic [ARM_CNT_W-1:0]   ARM_LAST   = ARM_CNT_W'(ARM_TIMEOUT - 1);
   localparam logic [QUIET_CNT_W-1:0] QUIET_LAST = QUIET_CNT_W'(FLUSH_QUIET - 1);
   localparam logic [LEN_W-1:0]       PREFILL_TH = LEN_W'(PREFILL_WORDS);

   state_t                 state;
   state_t                 state_n;
   logic [LEN_W-1:0]       play_len_q;
   logic [ARM_CNT_W-1:0]   arm_cnt;
   logic [QUIET_CNT_W-1:0] quiet_cnt;
   logic [LEN_W-1:0]       words_next;
   logic                   len_hit;
   logic [DATA_W-1:0]      word_out;

   // Per-cycle actions decided by the FSM and applied by the datapath.
   logic do_start;
   logic do_play;
   logic do_gap;
   logic do_timeout;
   logic do_done;

   assign words_next = words_played + LEN_W'(1);
   // A programmed length is reached when the word being accepted is the last one.
   assign len_hit    = (play_len_q != '0) && (words_next == play_len_q);

   // Sample order at the DAC port, optionally exchanging the two halves.
   always_comb begin
      word_out = fifo_dout;
      if (SWAP_HALVES != 0) begin
         word_out = {fifo_dout[SAMPLE_W-1:0], fifo_dout[DATA_W-1:SAMPLE_W]};
      end
   end

   // State register.
   always_ff @(posedge rd_clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_n;
      end
   end

   // Next-state logic and per-cycle action strobes.
   always_comb begin
      // NOTE: every variable gets a default before the case so no path can
      // leave it unassigned, which would otherwise infer a latch.
      state_n    = state;
      do_start   = 1'b0;
      do_play    = 1'b0;
      do_gap     = 1'b0;
      do_timeout = 1'b0;
      do_done    = 1'b0;

      case (state)
         IDLE: begin
            if (start && !stop) begin
               do_start = 1'b1;
               state_n  = PREFILL;
            end
         end

         PREFILL: begin
            // An abort wins over a prefill that completes in the same cycle.
            if (stop) begin
               state_n = IDLE;
            end else if (ddr_wr_word_cnt >= PREFILL_TH) begin
               state_n = ARM;
            end
         end

         ARM: begin
            if (fifo_dout_valid) begin
               // The first word is played even if it also ends the run.
               do_play = 1'b1;
               state_n = (stop || len_hit) ? FLUSH : PLAY;
            end else if (stop) begin
               state_n = FLUSH;
            end else if (arm_cnt == ARM_LAST) begin
               do_timeout = 1'b1;
               state_n    = FLUSH;
            end
         end

         PLAY: begin
            if (fifo_dout_valid) begin
               do_play = 1'b1;
               if (stop || len_hit) begin
                  state_n = FLUSH;
               end
            end else begin
               do_gap = 1'b1;
               if (stop) begin
                  state_n = FLUSH;
               end
            end
         end

         FLUSH: begin
            if (!fifo_dout_valid && (quiet_cnt == QUIET_LAST)) begin
               do_done = 1'b1;
               state_n = IDLE;
            end
         end

         default: begin
            state_n = IDLE;
         end
      endcase
   end

   // Registered outputs, counters and sticky flags.
   always_ff @(posedge rd_clk) begin
      if (rst) begin
         ctrl_rd_en   <= 1'b0;
         busy         <= 1'b0;
         done         <= 1'b0;
         dac_data     <= '0;
         dac_valid    <= 1'b0;
         underrun     <= 1'b0;
         timeout_err  <= 1'b0;
         words_played <= '0;
         play_len_q   <= '0;
         arm_cnt      <= '0;
         quiet_cnt    <= '0;
      end else begin
         // Status follows the state being entered so it lines up with it.
         ctrl_rd_en <= (state_n == ARM) || (state_n == PLAY);
         busy       <= (state_n != IDLE);
         done       <= do_done;

         // Arm counter runs only while waiting in ARM; zero on entry.
         if (state == ARM) begin
            arm_cnt <= arm_cnt + ARM_CNT_W'(1);
         end else begin
            arm_cnt <= '0;
         end

         // Quiet counter counts consecutive idle FLUSH cycles; zero on entry.
         if ((state == FLUSH) && !fifo_dout_valid) begin
            quiet_cnt <= quiet_cnt + QUIET_CNT_W'(1);
         end else begin
            quiet_cnt <= '0;
         end

         if (do_start) begin
            play_len_q   <= play_len;
            underrun     <= 1'b0;
            timeout_err  <= 1'b0;
            words_played <= '0;
         end

         if (do_timeout) begin
            timeout_err <= 1'b1;
         end

         if (do_gap) begin
            underrun <= 1'b1;
         end

         // Anything other than an accepted word mutes the DAC.
         if (do_play) begin
            dac_data     <= word_out;
            dac_valid    <= 1'b1;
            words_played <= words_next;
         end else begin
            dac_data  <= '0;
            dac_valid <= 1'b0;
         end
      end
   end

   // Saturating count of gap cycles seen during PLAY.
   sat_counter #(
      .W (UCNT_W)
   ) u_underrun_cnt (
      .rd_clk (rd_clk),
      .rst    (rst),
      .clr    (do_start),
      .inc    (do_gap),
      .cnt    (underrun_cnt)
   );

endmodule

// File: tb/tb_dac_playback_ctrl.sv
// Directed bench for dac_playback_ctrl. Two instances share all inputs:
// u_dut0 keeps sample order, u_dut1 swaps the halves.
`timescale 1ns/1ps
module tb_dac_playback_ctrl;

   localparam int LEN_W  = 32;
   localparam int DATA_W = 32;

   logic              rd_clk = 1'b0;
   logic              rst;
   logic              start;
   logic              stop;
   logic [LEN_W-1:0]  play_len;
   logic [LEN_W-1:0]  ddr_wr_word_cnt;
   logic [DATA_W-1:0] fifo_dout;
   logic              fifo_dout_valid;

   logic              ctrl_rd_en, dac_valid, underrun, timeout_err, busy, done;
   logic [DATA_W-1:0] dac_data;
   logic [15:0]       underrun_cnt;
   logic [LEN_W-1:0]  words_played;

   logic              sw_ctrl_rd_en, sw_dac_valid, sw_underrun, sw_timeout_err, sw_busy, sw_done;
   logic [DATA_W-1:0] sw_dac_data;
   logic [15:0]       sw_underrun_cnt;
   logic [LEN_W-1:0]  sw_words_played;

   logic [3:0] status;
   assign status = {busy, ctrl_rd_en, dac_valid, done};

   int tests_run    = 0;
   int tests_failed = 0;

   always #5 rd_clk = ~rd_clk;

   dac_playback_ctrl #(
      .PREFILL_WORDS (4), .ARM_TIMEOUT (16), .FLUSH_QUIET (4), .SWAP_HALVES (0)
   ) u_dut0 (
      .rd_clk (rd_clk), .rst (rst), .start (start), .stop (stop),
      .play_len (play_len), .ddr_wr_word_cnt (ddr_wr_word_cnt),
      .ctrl_rd_en (ctrl_rd_en), .fifo_dout (fifo_dout), .fifo_dout_valid (fifo_dout_valid),
      .dac_data (dac_data), .dac_valid (dac_valid), .underrun (underrun),
      .underrun_cnt (underrun_cnt), .timeout_err (timeout_err),
      .words_played (words_played), .busy (busy), .done (done)
   );

   dac_playback_ctrl #(
      .PREFILL_WORDS (4), .ARM_TIMEOUT (16), .FLUSH_QUIET (4), .SWAP_HALVES (1)
   ) u_dut1 (
      .rd_clk (rd_clk), .rst (rst), .start (start), .stop (stop),
      .play_len (play_len), .ddr_wr_word_cnt (ddr_wr_word_cnt),
      .ctrl_rd_en (sw_ctrl_rd_en), .fifo_dout (fifo_dout), .fifo_dout_valid (fifo_dout_valid),
      .dac_data (sw_dac_data), .dac_valid (sw_dac_valid), .underrun (sw_underrun),
      .underrun_cnt (sw_underrun_cnt), .timeout_err (sw_timeout_err),
      .words_played (sw_words_played), .busy (sw_busy), .done (sw_done)
   );

   // Requests a run and returns at the first ARM cycle (inputs may be driven at once).
   task automatic go_to_arm(input logic [LEN_W-1:0] len);
      @(negedge rd_clk);
      ddr_wr_word_cnt = 5;
      start = 1'b1; stop = 1'b0; play_len = len; fifo_dout_valid = 1'b0;
      @(negedge rd_clk);
      start = 1'b0;
      tests_run++;
      if (status !== 4'b1000) begin
         tests_failed++;
         $display("FAIL arm_prefill_status: got %b want 1000", status);
      end
      @(negedge rd_clk);
      tests_run++;
      if (status !== 4'b1100) begin
         tests_failed++;
         $display("FAIL arm_entry_status: got %b want 1100", status);
      end
   endtask

   // Waits a bounded number of cycles for the done pulse.
   task automatic wait_done(input int budget, input string tag);
      bit seen = 1'b0;
      for (int i = 0; i < budget && !seen; i++) begin
         @(negedge rd_clk);
         if (done === 1'b1) seen = 1'b1;
      end
      tests_run++;
      if (!seen) begin
         tests_failed++;
         $display("FAIL %s_done_timeout: no done within %0d cycles", tag, budget);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; stop = 1'b0; play_len = '0;
      ddr_wr_word_cnt = '0; fifo_dout = '0; fifo_dout_valid = 1'b0;
      repeat (3) @(negedge rd_clk);
      tests_run++;
      if (status !== 4'b0000) begin
         tests_failed++;
         $display("FAIL reset_status: got %b want 0000", status);
      end
      tests_run++;
      if ({dac_data, words_played, underrun_cnt, underrun, timeout_err} !== '0) begin
         tests_failed++;
         $display("FAIL reset_values: data %h words %0d ucnt %0d ur %b to %b, want all 0",
                  dac_data, words_played, underrun_cnt, underrun, timeout_err);
      end
      rst = 1'b0;
   endtask

   task automatic test_normal();
      logic [DATA_W-1:0] w;
      @(negedge rd_clk);
      start = 1'b1; play_len = 3; ddr_wr_word_cnt = 0;
      @(negedge rd_clk);
      start = 1'b0;
      for (int i = 1; i <= 3; i++) begin
         ddr_wr_word_cnt = LEN_W'(i);
         @(negedge rd_clk);
         tests_run++;
         if (status !== 4'b1000) begin
            tests_failed++;
            $display("FAIL normal_prefill_%0d: got %b want 1000", i, status);
         end
      end
      ddr_wr_word_cnt = 5;
      @(negedge rd_clk);
      tests_run++;
      if (status !== 4'b1100) begin
         tests_failed++;
         $display("FAIL normal_arm: got %b want 1100", status);
      end
      for (int i = 0; i < 4; i++) begin
         w = 32'hA + DATA_W'(i);
         fifo_dout = w; fifo_dout_valid = 1'b1;
         @(negedge rd_clk);
         tests_run++;
         if (i < 3) begin
            if (dac_data !== w || dac_valid !== 1'b1 || words_played !== LEN_W'(i + 1) ||
                ctrl_rd_en !== (i < 2) || sw_dac_data !== {w[15:0], w[31:16]}) begin
               tests_failed++;
               $display("FAIL normal_word_%0d: data %h sw %h dv %b words %0d rd_en %b, want %h %h 1 %0d %b",
                        i, dac_data, sw_dac_data, dac_valid, words_played, ctrl_rd_en,
                        w, {w[15:0], w[31:16]}, i + 1, (i < 2));
            end
         end else begin
            if (dac_data !== '0 || dac_valid !== 1'b0 || words_played !== 3 || ctrl_rd_en !== 1'b0) begin
               tests_failed++;
               $display("FAIL normal_discard: data %h dv %b words %0d rd_en %b, want 0 0 3 0",
                        dac_data, dac_valid, words_played, ctrl_rd_en);
            end
         end
      end
      fifo_dout_valid = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         @(negedge rd_clk);
         tests_run++;
         if (done !== (i == 4) || busy !== (i != 4)) begin
            tests_failed++;
            $display("FAIL normal_flush_%0d: done %b busy %b, want %b %b", i, done, busy, (i == 4), (i != 4));
         end
      end
      tests_run++;
      if (words_played !== 3) begin
         tests_failed++;
         $display("FAIL normal_words_final: got %0d want 3", words_played);
      end
   endtask

   task automatic test_underrun();
      bit          v_pat [5] = '{1, 1, 0, 0, 1};
      logic [15:0] c_pat [5] = '{0, 0, 1, 2, 2};
      logic [DATA_W-1:0] w;
      go_to_arm(0);
      for (int i = 0; i < 5; i++) begin
         w = 32'h100 + DATA_W'(i);
         fifo_dout = w; fifo_dout_valid = v_pat[i];
         @(negedge rd_clk);
         tests_run++;
         if (dac_valid !== v_pat[i] || dac_data !== (v_pat[i] ? w : '0) ||
             underrun_cnt !== c_pat[i] || underrun !== (i >= 2)) begin
            tests_failed++;
            $display("FAIL underrun_%0d: dv %b data %h ucnt %0d ur %b, want %b %h %0d %b",
                     i, dac_valid, dac_data, underrun_cnt, underrun,
                     v_pat[i], (v_pat[i] ? w : '0), c_pat[i], (i >= 2));
         end
      end
      fifo_dout_valid = 1'b0; stop = 1'b1;
      @(negedge rd_clk);
      stop = 1'b0;
      wait_done(20, "underrun");
   endtask

   task automatic test_timeout();
      go_to_arm(5);
      for (int i = 1; i <= 15; i++) begin
         @(negedge rd_clk);
         tests_run++;
         if (timeout_err !== 1'b0 || ctrl_rd_en !== 1'b1) begin
            tests_failed++;
            $display("FAIL timeout_wait_%0d: to %b rd_en %b, want 0 1", i, timeout_err, ctrl_rd_en);
         end
      end
      @(negedge rd_clk);
      tests_run++;
      if (timeout_err !== 1'b1 || ctrl_rd_en !== 1'b0 || busy !== 1'b1) begin
         tests_failed++;
         $display("FAIL timeout_hit: to %b rd_en %b busy %b, want 1 0 1", timeout_err, ctrl_rd_en, busy);
      end
      for (int i = 1; i <= 4; i++) begin
         @(negedge rd_clk);
         tests_run++;
         if (done !== (i == 4)) begin
            tests_failed++;
            $display("FAIL timeout_done_%0d: got %b want %b", i, done, (i == 4));
         end
      end
      ddr_wr_word_cnt = 0;
      start = 1'b1;
      @(negedge rd_clk);
      start = 1'b0;
      tests_run++;
      if (timeout_err !== 1'b0 || busy !== 1'b1) begin
         tests_failed++;
         $display("FAIL timeout_clear: to %b busy %b, want 0 1", timeout_err, busy);
      end
      stop = 1'b1;
      @(negedge rd_clk);
      stop = 1'b0;
      tests_run++;
      if (status !== 4'b0000) begin
         tests_failed++;
         $display("FAIL prefill_stop: got %b want 0000", status);
      end
      ddr_wr_word_cnt = 5;
   endtask

   task automatic test_stop_with_word();
      go_to_arm(0);
      fifo_dout = 32'h1111_2222; fifo_dout_valid = 1'b1;
      @(negedge rd_clk);
      fifo_dout = 32'h1234_5678; stop = 1'b1;
      @(negedge rd_clk);
      stop = 1'b0;
      tests_run++;
      if (sw_dac_data !== 32'h5678_1234 || dac_data !== 32'h1234_5678 || dac_valid !== 1'b1 ||
          ctrl_rd_en !== 1'b0 || words_played !== 2) begin
         tests_failed++;
         $display("FAIL stop_word: sw %h data %h dv %b rd_en %b words %0d, want 56781234 12345678 1 0 2",
                  sw_dac_data, dac_data, dac_valid, ctrl_rd_en, words_played);
      end
      for (int i = 0; i < 10; i++) begin
         fifo_dout = DATA_W'(i); fifo_dout_valid = 1'b1;
         start = (i == 3); stop = (i == 5);
         @(negedge rd_clk);
         tests_run++;
         if (status !== 4'b1000 || dac_data !== '0) begin
            tests_failed++;
            $display("FAIL stop_flush_%0d: status %b data %h, want 1000 0", i, status, dac_data);
         end
      end
      start = 1'b0; stop = 1'b0; fifo_dout_valid = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         @(negedge rd_clk);
         tests_run++;
         if (done !== (i == 4)) begin
            tests_failed++;
            $display("FAIL stop_done_%0d: got %b want %b", i, done, (i == 4));
         end
      end
      tests_run++;
      if (underrun_cnt !== 0 || underrun !== 1'b0) begin
         tests_failed++;
         $display("FAIL stop_no_gap: ucnt %0d ur %b, want 0 0", underrun_cnt, underrun);
      end
   endtask

   task automatic test_len_one();
      go_to_arm(1);
      fifo_dout = 32'hCAFE_F00D; fifo_dout_valid = 1'b1;
      @(negedge rd_clk);
      fifo_dout_valid = 1'b0;
      tests_run++;
      if (status !== 4'b1010 || dac_data !== 32'hCAFE_F00D || words_played !== 1) begin
         tests_failed++;
         $display("FAIL len_one: status %b data %h words %0d, want 1010 cafef00d 1",
                  status, dac_data, words_played);
      end
      wait_done(20, "len_one");
   endtask

   task automatic test_reset_mid_play();
      go_to_arm(0);
      for (int i = 0; i < 3; i++) begin
         fifo_dout = 32'h55 + DATA_W'(i); fifo_dout_valid = 1'b1;
         @(negedge rd_clk);
      end
      rst = 1'b1;
      @(negedge rd_clk);
      rst = 1'b0;
      tests_run++;
      if (status !== 4'b0000 || dac_data !== '0 || words_played !== '0) begin
         tests_failed++;
         $display("FAIL reset_mid_play: status %b data %h words %0d, want 0000 0 0",
                  status, dac_data, words_played);
      end
      for (int i = 0; i < 6; i++) begin
         @(negedge rd_clk);
         tests_run++;
         if (status !== 4'b0000) begin
            tests_failed++;
            $display("FAIL idle_ignore_%0d: got %b want 0000", i, status);
         end
      end
      fifo_dout_valid = 1'b0;
      start = 1'b1; stop = 1'b1;
      @(negedge rd_clk);
      start = 1'b0; stop = 1'b0;
      @(negedge rd_clk);
      tests_run++;
      if (status !== 4'b0000) begin
         tests_failed++;
         $display("FAIL start_with_stop: got %b want 0000", status);
      end
   endtask

   task automatic test_saturation();
      go_to_arm(0);
      fifo_dout = 32'h1; fifo_dout_valid = 1'b1;
      @(negedge rd_clk);
      fifo_dout_valid = 1'b0;
      repeat (65534) @(negedge rd_clk);
      tests_run++;
      if (underrun_cnt !== 16'hFFFE) begin
         tests_failed++;
         $display("FAIL sat_below: got %h want fffe", underrun_cnt);
      end
      repeat (70000 - 65534) @(negedge rd_clk);
      tests_run++;
      if (underrun_cnt !== 16'hFFFF || underrun !== 1'b1 || dac_valid !== 1'b0 || words_played !== 1) begin
         tests_failed++;
         $display("FAIL sat_hold: ucnt %h ur %b dv %b words %0d, want ffff 1 0 1",
                  underrun_cnt, underrun, dac_valid, words_played);
      end
      stop = 1'b1;
      @(negedge rd_clk);
      stop = 1'b0;
      wait_done(20, "sat");
   endtask

   initial begin
      test_reset();
      test_normal();
      test_underrun();
      test_timeout();
      test_stop_with_word();
      test_len_one();
      test_reset_mid_play();
      test_saturation();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

endmodule
